// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, clock divider width and default frame size.
package uart_pkg;

    localparam int unsigned DIV_W     = 15;
    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage flop synchronizer for asynchronous single-bit inputs; resets to 1 (idle-high).
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with ready/framing-error strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = uart_pkg::DATA_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     clock_div,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 frame_error,
    output logic                 rx_busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic rxs;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (rx),
        .q    (rxs)
    );

    uart_state_e          state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 tick;
    logic                 bit_val;

    assign tick = (cnt_q == '0);

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] holds rxs from counter==1, hist_q[1] from the cycle before that.
    logic [1:0] hist_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    assign bit_val = rxs;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = tick ? cnt_q : cnt_q - ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    div_d   = clock_div;
                    cnt_d   = (clock_div >> 1) - ONE;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = div_q - ONE;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    cnt_d   = div_q - ONE;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_val) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Held-low (break) line must return high before another start is accepted.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_ready    = ready_q;
    assign frame_error = ferr_q;
    assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: framing, back-to-back, glitch, break, reset, baud skew.
module tb_uart_rx;
    import uart_pkg::*;

    logic             clock;
    logic             reset;
    logic [DIV_W-1:0] clock_div;
    logic             rx;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             frame_error;
    logic             rx_busy;

    int n_tests;
    int n_fail;

    int         ready_cnt;
    int         fe_cnt;
    int         both_cnt;
    logic [7:0] rdq[$];

    uart_rx #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clock_div  (clock_div),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .frame_error(frame_error),
        .rx_busy    (rx_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        ready_cnt = 0;
        fe_cnt    = 0;
        both_cnt  = 0;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_ready) begin
                ready_cnt = ready_cnt + 1;
                rdq.push_back(rx_data);
            end
            if (frame_error) fe_cnt = fe_cnt + 1;
            if (rx_ready && frame_error) both_cnt = both_cnt + 1;
        end
    end

    // Drives one frame starting now; bit period in ns (10 ns clock). Optional one-clock glitch.
    task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_val,
                              input int glitch_bit, input int glitch_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                #(glitch_ns);
                rx = ~b[i];
                #10;
                rx = b[i];
                #(bit_ns - glitch_ns - 10);
            end else begin
                #(bit_ns);
            end
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    task automatic align();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        rx        = 1'b1;
        clock_div = 15'd217;
        repeat (4) @(negedge clock);
        n_tests++;
        if (rx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data);
        end
        n_tests++;
        if (rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_rx_ready got %b want 0", rx_ready);
        end
        n_tests++;
        if (frame_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_error got %b want 0", frame_error);
        end
        n_tests++;
        if (rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_rx_busy got %b want 0", rx_busy);
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_basic();
        int r0, f0;
        r0 = ready_cnt; f0 = fe_cnt;
        clock_div = 15'd217;
        align();
        send_frame(8'h41, 2170, 1'b1, -1, 0);
        repeat (20) @(negedge clock);
        n_tests++;
        if (ready_cnt - r0 !== 1) begin
            n_fail++; $display("FAIL basic_ready_pulses got %0d want 1", ready_cnt - r0);
        end
        n_tests++;
        if (rx_data !== 8'h41) begin
            n_fail++; $display("FAIL basic_rx_data got %h want 41", rx_data);
        end
        n_tests++;
        if (fe_cnt - f0 !== 0) begin
            n_fail++; $display("FAIL basic_frame_error got %0d want 0", fe_cnt - f0);
        end
        n_tests++;
        if (rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_after got %b want 0", rx_busy);
        end
    endtask

    task automatic test_back_to_back();
        int r0, q0;
        r0 = ready_cnt; q0 = rdq.size();
        align();
        send_frame(8'h00, 2170, 1'b1, -1, 0);
        send_frame(8'hFF, 2170, 1'b1, -1, 0);
        repeat (20) @(negedge clock);
        n_tests++;
        if (ready_cnt - r0 !== 2) begin
            n_fail++; $display("FAIL b2b_ready_pulses got %0d want 2", ready_cnt - r0);
        end
        if (rdq.size() >= q0 + 2) begin
            n_tests++;
            if (rdq[q0] !== 8'h00) begin
                n_fail++; $display("FAIL b2b_first_byte got %h want 00", rdq[q0]);
            end
            n_tests++;
            if (rdq[q0+1] !== 8'hFF) begin
                n_fail++; $display("FAIL b2b_second_byte got %h want ff", rdq[q0+1]);
            end
        end
    endtask

    task automatic test_start_glitch();
        int r0, f0;
        r0 = ready_cnt; f0 = fe_cnt;
        align();
        rx = 1'b0;
        repeat (50) @(negedge clock);
        rx = 1'b1;
        repeat (300) @(negedge clock);
        n_tests++;
        if ((ready_cnt - r0) + (fe_cnt - f0) !== 0) begin
            n_fail++;
            $display("FAIL glitch_strobes got %0d want 0", (ready_cnt - r0) + (fe_cnt - f0));
        end
        n_tests++;
        if (rx_data !== 8'hFF) begin
            n_fail++; $display("FAIL glitch_rx_data got %h want ff", rx_data);
        end
        n_tests++;
        if (rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL glitch_busy got %b want 0", rx_busy);
        end
    endtask

    task automatic test_frame_error();
        int r0, f0;
        r0 = ready_cnt; f0 = fe_cnt;
        align();
        send_frame(8'h55, 2170, 1'b0, -1, 0);
        repeat (3000) @(negedge clock);
        n_tests++;
        if (fe_cnt - f0 !== 1) begin
            n_fail++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - f0);
        end
        n_tests++;
        if (ready_cnt - r0 !== 0) begin
            n_fail++; $display("FAIL ferr_no_ready got %0d want 0", ready_cnt - r0);
        end
        n_tests++;
        if (rx_busy !== 1'b1) begin
            n_fail++; $display("FAIL ferr_busy_while_low got %b want 1", rx_busy);
        end
        n_tests++;
        if (rx_data !== 8'hFF) begin
            n_fail++; $display("FAIL ferr_rx_data_kept got %h want ff", rx_data);
        end
        rx = 1'b1;
        repeat (20) @(negedge clock);
        n_tests++;
        if (rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL ferr_idle_after_high got %b want 0", rx_busy);
        end
        align();
        send_frame(8'h3C, 2170, 1'b1, -1, 0);
        repeat (20) @(negedge clock);
        n_tests++;
        if (ready_cnt - r0 !== 1 || rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL ferr_recover got %0d/%h want 1/3c", ready_cnt - r0, rx_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0, f0;
        logic [7:0] b;
        b = 8'hA5;
        r0 = ready_cnt; f0 = fe_cnt;
        align();
        rx = 1'b0;
        #2170;
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #2170;
        end
        rx = b[4];
        #1000;
        @(negedge clock);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (rx_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_rx_data got %h want 00", rx_data);
        end
        n_tests++;
        if (rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_busy got %b want 0", rx_busy);
        end
        repeat (3000) @(negedge clock);
        n_tests++;
        if ((ready_cnt - r0) + (fe_cnt - f0) !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_strobes got %0d want 0", (ready_cnt - r0) + (fe_cnt - f0));
        end
        align();
        send_frame(8'h5A, 2170, 1'b1, -1, 0);
        repeat (20) @(negedge clock);
        n_tests++;
        if (ready_cnt - r0 !== 1 || rx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL rst_mid_next got %0d/%h want 1/5a", ready_cnt - r0, rx_data);
        end
    endtask

    task automatic test_baud_tolerance();
        int r0;
        int bit_ns[2];
        bit_ns[0] = 155;
        bit_ns[1] = 165;
        clock_div = 15'd16;
        repeat (5) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            r0 = ready_cnt;
            align();
            send_frame(8'hC3, bit_ns[k], 1'b1, -1, 0);
            repeat (20) @(negedge clock);
            n_tests++;
            if (ready_cnt - r0 !== 1 || rx_data !== 8'hC3) begin
                n_fail++;
                $display("FAIL tol_%0dns got %0d/%h want 1/c3", bit_ns[k], ready_cnt - r0, rx_data);
            end
        end
        r0 = ready_cnt;
        align();
        send_frame(8'h00, 160, 1'b1, -1, 0);
        repeat (20) @(negedge clock);
        n_tests++;
        if (ready_cnt - r0 !== 1 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL tol_div16_zero got %0d/%h want 1/00", ready_cnt - r0, rx_data);
        end
`ifdef UART_RX_MAJORITY_EN
        r0 = ready_cnt;
        align();
        // One-clock pulse lands on the bit-2 sample point.
        send_frame(8'hC3, 160, 1'b1, 2, 80);
        repeat (20) @(negedge clock);
        n_tests++;
        if (ready_cnt - r0 !== 1 || rx_data !== 8'hC3) begin
            n_fail++; $display("FAIL maj_glitch got %0d/%h want 1/c3", ready_cnt - r0, rx_data);
        end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_baud_tolerance();
        n_tests++;
        if (both_cnt !== 0) begin
            n_fail++; $display("FAIL ready_and_ferr_overlap got %0d want 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, 8N1, LSB first, idle-high line. It is the receive half of the design's existing UART transmitter and is driven by the same clock_div value (clocks per bit; 217 at 50 MHz gives 230400 baud). It sits beside the transmitter in the board top. It delivers each received byte with a one-cycle strobe and flags framing errors.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first)
SYNC_STAGES, 2, flip-flop stages in the rx input synchronizer (minimum 2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
clock_div  input  15  clock cycles per bit period; supported range 8..32767
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last correctly received byte
rx_ready  output  1  one-cycle strobe: rx_data updated this cycle
frame_error  output  1  one-cycle strobe: stop bit sampled low
rx_busy  output  1  high while a frame is in progress (any state but IDLE)

Behaviour:
- Reset values: rx_data=0, rx_ready=0, frame_error=0, rx_busy=0, state=IDLE. Synchronizer flops reset to 1.
- rx passes through SYNC_STAGES flops; all logic uses the synchronized value rxs.
- clock_div is latched into div_q on leaving IDLE and is held constant for the whole frame. A mid-frame change affects only the next frame.
- half = div_q >> 1. The bit counter counts down from its loaded value to 0; the sample point is the cycle where the counter reaches 0.
- IDLE: when rxs=0, load counter with half-1 and go to START.
- START: at sample, if rxs=1 (glitch), return to IDLE with no strobes. Otherwise load div_q-1, clear the bit index, and go to DATA.
- DATA: at each sample, shift rxs into the shift register MSB (LSB-first frame), then reload div_q-1. After DATA_BITS samples, go to STOP.
- STOP: at sample:
  - rxs=1: rx_data <= shift register, rx_ready=1 for exactly one cycle (the cycle after the sample), go to IDLE.
  - rxs=0: frame_error=1 for one cycle, rx_data unchanged, rx_ready not asserted, go to WAIT_IDLE.
- WAIT_IDLE: remain until rxs=1 (break/held-low line), then go to IDLE. No new frame starts while rx stays low.
- Latency: rx_ready rises SYNC_STAGES + (DATA_BITS+1)*div_q + half + 1 cycles (±1) after the falling edge on rx.
- Back-to-back frames: returning to IDLE at the stop mid-bit allows a start bit immediately after the stop bit to be caught. No dead time is required.
- rx_ready and frame_error are never high in the same cycle.
- Reset asserted mid-frame: return to IDLE next cycle. Partial byte discarded, no strobes, rx_data cleared.
- clock_div < 8: behaviour undefined (not verified).

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: every sample (start, data, stop) is the 2-of-3 majority of rxs taken at counter values 1, 0 and the cycle before 1. A one-cycle glitch at the sample point is rejected. Timing is otherwise unchanged.
- Undefined: single sample of rxs at counter==0, with no extra registers.

Decomposition:
- Shared package uart_pkg holds:
  - State enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - DIV_W=15.
  - Default DATA_BITS=8.
  The transmitter shares DIV_W and DATA_BITS from the same package.
- One natural sub-module: uart_sync (parameterized SYNC_STAGES flop chain, reset to 1), reusable for KEY inputs in the board top.

Test Plan:
- clock_div=217; send 0x41 with ideal timing -> exactly one rx_ready pulse, rx_data=0x41, frame_error never high, rx_busy low afterwards.
- clock_div=217; frames 0x00 then 0xFF with zero gap -> two rx_ready pulses, rx_data 0x00 then 0xFF.
- rx low for 50 cycles then high (clock_div=217) -> return to IDLE; no rx_ready or frame_error; rx_data unchanged.
- 0x55 with stop bit driven 0, line held low 3000 cycles, then a valid 0x3C -> one frame_error pulse and no rx_ready for the first frame; no activity while low; then rx_ready with rx_data=0x3C.
- reset pulsed during bit 4 of 0xA5, then a clean 0x5A -> rx_data=0 after reset, no strobe for the aborted frame, next rx_ready has rx_data=0x5A.
- clock_div=16; 0xC3 sent with bit periods at ±3% -> rx_data=0xC3. With UART_RX_MAJORITY_EN, add a 1-cycle glitch at the bit-2 sample point -> still 0xC3.
